// File: rtl/gpp_calc_iter_unit.sv
// Iterative MUL / FACT / POW coprocessor for the gpp_calc core.
// One shift-add multiplier step per cycle; result and flags held between operations.
module gpp_calc_iter_unit #(
   parameter int WIDTH = 16,
   parameter int OPW   = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       op,
   input  logic [OPW-1:0]   opa,
   input  logic [OPW-1:0]   opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             err
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_MUL  = 3'd2;
   localparam logic [2:0] S_NEXT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [1:0] OP_MUL  = 2'd0;
   localparam logic [1:0] OP_FACT = 2'd1;
   localparam logic [1:0] OP_POW  = 2'd2;
   localparam logic [1:0] OP_ILL  = 2'd3;

   logic [2:0]       state, state_n;
   logic [1:0]       op_r;
   logic [OPW-1:0]   opa_r, opb_r;
   logic [WIDTH-1:0] acc, acc_n;
   logic [WIDTH-1:0] fac, fac_n;
   logic [OPW-1:0]   cnt, cnt_n;
   logic             csticky, csticky_n;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH-1:0] hi, lo;
   logic [WIDTH:0]   sum;

   function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] a, input logic c);
      calc_flags = {(a == '0), a[WIDTH-1], c, c | a[WIDTH-1]};
   endfunction

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   // {hi, lo} is the 2*WIDTH product; lo starts as the multiplier and shifts out LSB first.
   assign sum = {1'b0, hi} + (lo[0] ? {1'b0, acc} : '0);

   always_comb begin
      state_n   = state;
      acc_n     = acc;
      fac_n     = fac;
      cnt_n     = cnt;
      csticky_n = csticky;
      case (state)
         S_IDLE: if (start) state_n = S_LOAD;
         S_LOAD: begin
            csticky_n = 1'b0;
            case (op_r)
               OP_MUL: begin
                  acc_n = WIDTH'(opa_r);
                  fac_n = WIDTH'(opb_r);
                  cnt_n = OPW'(1);
               end
               OP_FACT: begin
                  acc_n = WIDTH'(1);
                  fac_n = WIDTH'(2);
                  cnt_n = (opa_r <= OPW'(1)) ? '0 : opa_r - OPW'(1);
               end
               OP_POW: begin
                  acc_n = WIDTH'(1);
                  fac_n = WIDTH'(opa_r);
                  cnt_n = opb_r;
               end
               default: begin
                  acc_n = '0;
                  fac_n = '0;
                  cnt_n = '0;
               end
            endcase
            state_n = (cnt_n != '0) ? S_MUL : S_DONE;
         end
         S_MUL: if (bit_cnt == BW'(WIDTH - 1)) state_n = S_NEXT;
         S_NEXT: begin
            acc_n     = lo;
            csticky_n = csticky | (hi != '0);
            cnt_n     = cnt - OPW'(1);
            if (op_r == OP_FACT) fac_n = fac + WIDTH'(1);
            state_n   = (cnt_n != '0) ? S_MUL : S_DONE;
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (abort && state != S_IDLE) state_n = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         result <= '0;
         flags  <= '0;
         err    <= 1'b0;
      end else begin
         state <= state_n;
         // Outputs load on entry to DONE so they are valid in the done cycle.
         if (state_n == S_DONE && state != S_DONE) begin
            result <= acc_n;
            flags  <= calc_flags(acc_n, csticky_n);
            err    <= (op_r == OP_ILL);
         end
      end
   end

   always_ff @(posedge clk) begin
      acc     <= acc_n;
      fac     <= fac_n;
      cnt     <= cnt_n;
      csticky <= csticky_n;
      if (state == S_IDLE && start) begin
         op_r  <= op;
         opa_r <= opa;
         opb_r <= opb;
      end
      if (state_n == S_MUL && state != S_MUL) begin
         hi      <= '0;
         lo      <= fac_n;
         bit_cnt <= '0;
      end else if (state == S_MUL) begin
         hi      <= sum[WIDTH:1];
         lo      <= {sum[0], lo[WIDTH-1:1]};
         bit_cnt <= bit_cnt + BW'(1);
      end
   end

endmodule

// File: tb/tb_gpp_calc_iter_unit.sv
// Scoreboard bench for gpp_calc_iter_unit: driver pushes expectations from an
// arithmetic reference model, a monitor pops and compares on every done pulse.
module tb_gpp_calc_iter_unit;
   localparam int W  = 16;
   localparam int OW = 9;
   localparam longint CAP = 64'd1 << 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [1:0]    op = 2'd0;
   logic [OW-1:0] opa = '0;
   logic [OW-1:0] opb = '0;
   logic          busy, done, err;
   logic [W-1:0]  result;
   logic [3:0]    flags;

   typedef struct packed {
      logic [W-1:0] res;
      logic [3:0]   fl;
      logic         er;
      int           at;
   } exp_t;

   exp_t         sbq[$];
   int           tests = 0;
   int           fails = 0;
   int           cyc = 0;
   logic [W-1:0] last_res = '0;
   logic [3:0]   last_fl = '0;
   logic         last_err = 1'b0;

   gpp_calc_iter_unit #(.WIDTH(W), .OPW(OW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
      .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
      .flags(flags), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint got, input longint expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, expv);
      end
   endtask

   // True mathematical value tracked exactly up to CAP (enough to decide >= 2^W),
   // low W bits tracked separately.
   function automatic exp_t model(input logic [1:0] o, input int a, input int b);
      exp_t   e;
      longint t;
      longint low;
      int     m;
      logic   carry;
      t = 0; low = 0; m = 0;
      case (o)
         2'd0: begin
            t = longint'(a) * b; low = t % 65536; m = 1;
         end
         2'd1: begin
            t = 1; low = 1;
            for (int k = 2; k <= a; k++) begin
               t = (t * k > CAP) ? CAP : t * k;
               low = (low * k) % 65536;
            end
            m = (a <= 1) ? 0 : a - 1;
         end
         2'd2: begin
            t = 1; low = 1;
            for (int k = 0; k < b; k++) begin
               t = (t * a > CAP) ? CAP : t * a;
               low = (low * a) % 65536;
            end
            m = b;
         end
         default: begin
            t = 0; low = 0; m = 0;
         end
      endcase
      carry = (t >= 65536);
      e.res = W'(low);
      e.fl  = {(low == 0), e.res[W-1], carry, carry | e.res[W-1]};
      e.er  = (o == 2'd3);
      e.at  = 2 + m * (W + 1);
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: result %0h flags %0h, expected no done", result, flags);
         end else begin
            e = sbq.pop_front();
            check("result", result, e.res);
            check("flags", flags, e.fl);
            check("err", err, e.er);
            check("done_cycle", cyc, e.at);
            last_res = e.res;
            last_fl  = e.fl;
            last_err = e.er;
         end
      end
   end

   task automatic issue(input logic [1:0] o, input int a, input int b, input bit push, output int c0);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL idle_wait: busy %0b, expected 0", busy);
      end
      op = o; opa = OW'(a); opb = OW'(b); start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      start = 1'b0;
      if (push) begin
         e = model(o, a, b);
         e.at = c0 + e.at - 1;
         sbq.push_back(e);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d pending, expected 0", sbq.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int c;
      logic [1:0] o;
      int a, b;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      rst = 1'b0;

      issue(2'd0, 300, 200, 1, c);
      issue(2'd1, 8, 0, 1, c);
      issue(2'd1, 9, 0, 1, c);
      issue(2'd2, 2, 16, 1, c);
      issue(2'd2, 7, 0, 1, c);
      issue(2'd1, 0, 0, 1, c);
      issue(2'd1, 1, 0, 1, c);
      issue(2'd3, 5, 6, 1, c);
      issue(2'd2, 0, 3, 1, c);
      issue(2'd0, 511, 511, 1, c);

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom_range(0, 511);
         b = $urandom_range(0, 511);
         if (o == 2'd1) a = $urandom_range(0, 14);
         if (o == 2'd2) b = $urandom_range(0, 12);
         issue(o, a, b, 1, c);
      end
      drain();

      issue(2'd0, 123, 45, 1, c);
      wait_until(c + 4);
      op = 2'd2; opa = OW'(3); opb = OW'(5); start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain();

      issue(2'd1, 8, 0, 0, c);
      wait_until(c + 39);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_busy", busy, 0);
      repeat (150) @(negedge clk);
      check("abort_result", result, last_res);
      check("abort_flags", flags, last_fl);
      check("abort_err", err, last_err);

      issue(2'd1, 8, 0, 0, c);
      wait_until(c + 49);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_result", result, 0);
      check("midrst_flags", flags, 0);
      check("midrst_err", err, 0);
      issue(2'd0, 3, 4, 1, c);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
